// File: rtl/hsi_tx_arb.sv
// hsi_tx_arb: round-robin arbiter sharing the HSI output byte coder between
// two message sources. A grant covers a whole message. Each granted byte goes
// to the coder as a one-cycle write strobe, paced by the coder busy flag.
// Optional feature macro: HSI_TX_ARB_WDT_EN adds an idle watchdog in XFER.
module hsi_tx_arb #(
    parameter int ACK_TMO = 8,
    parameter int WDT_CYC = 4095
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    input  logic [7:0] i_d0,
    input  logic [7:0] i_d1,
    input  logic [1:0] i_rdy,
    input  logic [1:0] i_eom,
    input  logic       i_cd_busy,
    output logic [7:0] o_cd_d,
    output logic       o_cd_wr,
    output logic       o_arb_busy,
    output logic       o_abort
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GNT  = 3'd1,
        XFER = 3'd2,
        ACK  = 3'd3,
        BSY  = 3'd4,
        DONE = 3'd5,
        REL  = 3'd6
    } state_t;

    localparam int TW = $clog2(ACK_TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TMO - 1);

    // Parameter sanity: the timeout needs at least one cycle and the watchdog is 12 bits wide
    if (ACK_TMO < 1 || WDT_CYC < 1 || WDT_CYC > 4096) begin : g_bad_param
        $error("hsi_tx_arb: ACK_TMO or WDT_CYC out of range");
    end

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_gnt;
    logic          r_last;
    logic [7:0]    r_cd_d;
    logic          r_cd_wr;
    logic          r_abort;
    logic          r_pend;
    logic [TW-1:0] r_tmo;

    logic          w_rdy;
    logic          w_eom;
    logic [7:0]    w_d;
    logic          w_win;
    logic          w_grant;
    logic          w_wr;
    logic          w_abort;
    logic          w_set_pend;

    // Only the granted source's rdy, eom and data are ever looked at
    assign w_rdy = |(i_rdy & r_gnt);
    assign w_eom = |(i_eom & r_gnt);
    assign w_d   = r_gnt[1] ? i_d1 : i_d0;

    // Single requester wins outright; on a tie the source not served last wins
    assign w_win = (i_req == 2'b10) ? 1'b1 :
                   (i_req == 2'b01) ? 1'b0 : ~r_last;

`ifdef HSI_TX_ARB_WDT_EN
    localparam logic [11:0] WDT_LAST = 12'(WDT_CYC - 1);
    logic [11:0] r_wdt;
    logic        w_wdt_hit;

    assign w_wdt_hit = (r_wdt == WDT_LAST);

    // Watchdog counts silent XFER cycles; any exit from XFER (including a write) clears it
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wdt <= 12'd0;
        end else if ((r_state != XFER) || (w_next != XFER)) begin
            r_wdt <= 12'd0;
        end else if (!w_rdy && !w_eom) begin
            r_wdt <= r_wdt + 12'd1;
        end
    end
`endif

    // Next-state and strobe decode for the message FSM
    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_wr       = 1'b0;
        w_abort    = 1'b0;
        w_set_pend = 1'b0;
        case (r_state)
            IDLE: begin
                if ((i_req != 2'b00) && !i_cd_busy) begin
                    w_grant = 1'b1;
                    w_next  = GNT;
                end
            end
            GNT: w_next = XFER;
            XFER: begin
                if (w_rdy) begin
                    if (!i_cd_busy) begin
                        w_wr       = 1'b1;
                        w_set_pend = w_eom;
                        w_next     = ACK;
                    end
                end else if (w_eom) begin
                    w_next = DONE;
                end
`ifdef HSI_TX_ARB_WDT_EN
                else if (w_wdt_hit) begin
                    w_abort = 1'b1;
                    w_next  = REL;
                end
`endif
            end
            ACK: begin
                if (i_cd_busy) begin
                    w_next = BSY;
                end else if (r_tmo == TMO_LAST) begin
                    w_abort = 1'b1;
                    w_next  = REL;
                end
            end
            BSY: begin
                if (!i_cd_busy) begin
                    w_next = (r_pend || w_eom) ? DONE : XFER;
                end
            end
            DONE: begin
                if (!i_cd_busy) begin
                    w_next = REL;
                end
            end
            REL:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant, round-robin memory, coder byte/strobe, abort pulse and pending end-of-message
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_gnt   <= 2'b00;
            r_last  <= 1'b1;
            r_cd_d  <= 8'h00;
            r_cd_wr <= 1'b0;
            r_abort <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_cd_wr <= w_wr;
            r_abort <= w_abort;
            if (w_wr) begin
                r_cd_d <= w_d;
            end
            if (w_grant) begin
                r_gnt  <= w_win ? 2'b10 : 2'b01;
                r_last <= w_win;
            end else if (r_state == REL) begin
                r_gnt <= 2'b00;
            end
            if (r_state == REL) begin
                r_pend <= 1'b0;
            end else if (w_set_pend) begin
                r_pend <= 1'b1;
            end
        end
    end

    // Per-state cycle counter: cleared on every state change, saturates instead of wrapping
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tmo <= '0;
        end else if (w_next != r_state) begin
            r_tmo <= '0;
        end else if (r_tmo != {TW{1'b1}}) begin
            r_tmo <= r_tmo + TW'(1);
        end
    end

    assign o_gnt      = r_gnt;
    assign o_cd_d     = r_cd_d;
    assign o_cd_wr    = r_cd_wr;
    assign o_abort    = r_abort;
    assign o_arb_busy = (r_state != IDLE);

endmodule
